// File: rtl/sd_burst_loader_if.sv
// Handshake bundle between sd_reader, the burst loader and the memory-init controller.
// The loader owns the master modport; the surrounding environment owns the slave modport.
interface sd_burst_loader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              rstart;
    logic [31:0]       rsector;
    logic              rdone;
    logic              outen;
    logic [7:0]        outbyte;
    logic [DATA_W-1:0] DATA;
    logic [ADDR_W-1:0] WADDR;
    logic              WE;
    logic              wready;

    modport master (
        output rstart, rsector, DATA, WADDR, WE,
        input  rdone, outen, outbyte, wready
    );

    modport slave (
        input  rstart, rsector, DATA, WADDR, WE,
        output rdone, outen, outbyte, wready
    );
endinterface

// File: rtl/sd_burst_loader.sv
// Ping-pong SD image loader: fills two 512-byte sector buffers from sd_reader and drains them
// as DATA_W-bit little-endian words. Define SD_BURST_LOADER_CHECKSUM_EN to add the csum output.
module sd_burst_loader #(
    parameter int DATA_W       = 32,
    parameter int BIN_BYTES    = 4194304,
    parameter int START_SECTOR = 0,
    parameter int ADDR_W       = 32
) (
    input  logic                   clk27mhz,
    input  logic                   resetn,
    input  logic                   go,
    sd_burst_loader_if.master      bus,
    output logic                   DONE,
    output logic                   busy
`ifdef SD_BURST_LOADER_CHECKSUM_EN
    ,
    output logic [31:0]            csum
`endif
);
    localparam int                NB         = DATA_W / 8;
    localparam int                NSECT      = (BIN_BYTES + 511) / 512;
    localparam logic [ADDR_W:0]   IMG_END    = (ADDR_W+1)'(BIN_BYTES);
    localparam logic [ADDR_W-1:0] SECT_TOTAL = ADDR_W'(NSECT);
    localparam logic [9:0]        STEP       = 10'(NB);

    typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} buf_state_t;
    typedef enum logic [1:0] {F_IDLE, F_REQ, F_WAIT}                  fill_state_t;
    typedef enum logic [1:0] {D_IDLE, D_LOAD, D_PRESENT}              drain_state_t;

    buf_state_t        buf_st [2];
    fill_state_t       f_state, f_next;
    drain_state_t      d_state, d_next;
    logic              fill_sel, drain_sel;
    logic [9:0]        wr_idx, rd_idx;
    logic [ADDR_W-1:0] byte_cnt, sectors_issued, waddr_q;
    logic [31:0]       rsector_q;
    logic [DATA_W-1:0] data_q, load_word;
    logic [7:0]        buf_mem [2][512];
    logic              done_q, busy_q;
    logic              xfer, last_word, buf_exhausted, release_buf, fill_free, fill_start;
    logic              byte_wr;

    assign xfer          = (d_state == D_PRESENT) && bus.wready;
    assign last_word     = ({1'b0, byte_cnt} + (ADDR_W+1)'(NB)) >= IMG_END;
    assign buf_exhausted = (rd_idx + STEP) == 10'd512;
    assign release_buf   = xfer && (last_word || buf_exhausted);
    // A buffer being released this cycle may be claimed by the fill side in the same cycle.
    assign fill_free     = (buf_st[fill_sel] == B_EMPTY) || (release_buf && (drain_sel == fill_sel));
    assign byte_wr       = (f_state == F_WAIT) && bus.outen && !wr_idx[9];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        f_next = f_state;
        case (f_state)
            F_IDLE: if (go && !done_q && fill_free && (sectors_issued < SECT_TOTAL)) f_next = F_REQ;
            F_REQ:  f_next = F_WAIT;
            F_WAIT: if (bus.rdone) f_next = F_IDLE;
            default: f_next = F_IDLE;
        endcase
    end

    assign fill_start = (f_state == F_IDLE) && (f_next == F_REQ);

    always_comb begin
        d_next = d_state;
        case (d_state)
            D_IDLE:    if (!done_q && (buf_st[drain_sel] == B_FULL)) d_next = D_LOAD;
            D_LOAD:    d_next = D_PRESENT;
            D_PRESENT: if (xfer) d_next = release_buf ? D_IDLE : D_LOAD;
            default:   d_next = D_IDLE;
        endcase
    end

    // Bytes at or beyond the image end are forced to zero in the final word.
    always_comb begin
        load_word = '0;
        for (int j = 0; j < NB; j++) begin
            if (({1'b0, byte_cnt} + (ADDR_W+1)'(j)) < IMG_END)
                load_word[8*j +: 8] = buf_mem[drain_sel][rd_idx[8:0] + 9'(j)];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk27mhz or negedge resetn) begin
        if (!resetn) begin
            f_state <= F_IDLE;
            d_state <= D_IDLE;
        end else begin
            f_state <= f_next;
            d_state <= d_next;
        end
    end

    always_ff @(posedge clk27mhz or negedge resetn) begin
        if (!resetn) begin
            buf_st[0]      <= B_EMPTY;
            buf_st[1]      <= B_EMPTY;
            fill_sel       <= 1'b0;
            drain_sel      <= 1'b0;
            wr_idx         <= '0;
            rd_idx         <= '0;
            byte_cnt       <= '0;
            sectors_issued <= '0;
            rsector_q      <= 32'(START_SECTOR);
            data_q         <= '0;
            waddr_q        <= '0;
            done_q         <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            if (IMG_END == '0) done_q <= 1'b1;

            if ((d_state == D_IDLE) && (d_next == D_LOAD)) buf_st[drain_sel] <= B_DRAINING;
            if (d_state == D_LOAD) begin
                data_q  <= load_word;
                waddr_q <= byte_cnt;
            end
            if (xfer) begin
                byte_cnt <= byte_cnt + ADDR_W'(NB);
                rd_idx   <= rd_idx + STEP;
                if (release_buf) begin
                    buf_st[drain_sel] <= B_EMPTY;
                    drain_sel         <= ~drain_sel;
                    rd_idx            <= '0;
                end
                if (last_word) begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                end
            end

            // Fill updates come last so a same-cycle claim overrides the drain's release.
            if (fill_start) begin
                buf_st[fill_sel] <= B_FILLING;
                sectors_issued   <= sectors_issued + ADDR_W'(1);
                wr_idx           <= '0;
                busy_q           <= 1'b1;
            end
            if (byte_wr) wr_idx <= wr_idx + 10'd1;
            if ((f_state == F_WAIT) && bus.rdone) begin
                buf_st[fill_sel] <= B_FULL;
                rsector_q        <= rsector_q + 32'd1;
                fill_sel         <= ~fill_sel;
            end
        end
    end

    // NOTE: sector buffers carry no reset; buffer state flags alone say which contents are valid.
    always_ff @(posedge clk27mhz) begin
        if (byte_wr) buf_mem[fill_sel][wr_idx[8:0]] <= bus.outbyte;
    end

`ifdef SD_BURST_LOADER_CHECKSUM_EN
    logic [31:0] word_sum, csum_q;

    // Pad bytes are already zero in data_q, so summing every lane excludes them.
    always_comb begin
        word_sum = '0;
        for (int j = 0; j < NB; j++) word_sum = word_sum + 32'(data_q[8*j +: 8]);
    end

    always_ff @(posedge clk27mhz or negedge resetn) begin
        if (!resetn)   csum_q <= '0;
        else if (xfer) csum_q <= csum_q + word_sum;
    end

    assign csum = csum_q;
`endif

    assign bus.rstart  = (f_state == F_REQ);
    assign bus.rsector = rsector_q;
    assign bus.DATA    = data_q;
    assign bus.WADDR   = waddr_q;
    assign bus.WE      = (d_state == D_PRESENT);
    assign DONE        = done_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_sd_burst_loader.sv
// Directed bench for sd_burst_loader: 32-bit and 64-bit images, ping-pong stall, go pause,
// asynchronous reset mid-drain and the empty image.
`timescale 1ns/1ps
module tb_sd_burst_loader;
    logic clk27mhz = 1'b0;
    logic resetn;
    logic go_a, go_b, go_c;
    logic done_a, done_b, done_c, busy_a, busy_b, busy_c;
`ifdef SD_BURST_LOADER_CHECKSUM_EN
    logic [31:0] csum_a, csum_b, csum_c;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #18 clk27mhz = ~clk27mhz;

    sd_burst_loader_if #(.DATA_W(32), .ADDR_W(32)) bus_a ();
    sd_burst_loader_if #(.DATA_W(64), .ADDR_W(32)) bus_b ();
    sd_burst_loader_if #(.DATA_W(32), .ADDR_W(32)) bus_c ();

    sd_burst_loader #(.DATA_W(32), .BIN_BYTES(1024), .START_SECTOR(8), .ADDR_W(32)) u_a (
        .clk27mhz(clk27mhz), .resetn(resetn), .go(go_a), .bus(bus_a), .DONE(done_a), .busy(busy_a)
`ifdef SD_BURST_LOADER_CHECKSUM_EN
        , .csum(csum_a)
`endif
    );

    sd_burst_loader #(.DATA_W(64), .BIN_BYTES(1030), .START_SECTOR(0), .ADDR_W(32)) u_b (
        .clk27mhz(clk27mhz), .resetn(resetn), .go(go_b), .bus(bus_b), .DONE(done_b), .busy(busy_b)
`ifdef SD_BURST_LOADER_CHECKSUM_EN
        , .csum(csum_b)
`endif
    );

    sd_burst_loader #(.DATA_W(32), .BIN_BYTES(0), .START_SECTOR(0), .ADDR_W(32)) u_c (
        .clk27mhz(clk27mhz), .resetn(resetn), .go(go_c), .bus(bus_c), .DONE(done_c), .busy(busy_c)
`ifdef SD_BURST_LOADER_CHECKSUM_EN
        , .csum(csum_c)
`endif
    );

    // Card byte at image offset a is a mod 256; bytes past the image end read as zero.
    function automatic logic [63:0] exp_word(int addr, int nb, int bin);
        logic [63:0] w = '0;
        for (int j = 0; j < nb; j++)
            if (addr + j < bin) w[8*j +: 8] = 8'((addr + j) % 256);
        return w;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk27mhz);
            #1;
        end
    endtask

    // Card models: a short latency, 512 sector bytes plus one stray 513th strobe, then rdone.
    initial begin
        bus_a.outen = 1'b0; bus_a.rdone = 1'b0; bus_a.outbyte = 8'h00;
        forever begin
            @(negedge clk27mhz);
            if (resetn && bus_a.rstart) begin
                for (int i = 0; i < 6 && resetn; i++) @(negedge clk27mhz);
                for (int i = 0; i < 513 && resetn; i++) begin
                    bus_a.outen = 1'b1;
                    bus_a.outbyte = (i == 512) ? 8'hAA : 8'(i);
                    @(negedge clk27mhz);
                end
                bus_a.outen = 1'b0;
                if (resetn) begin
                    bus_a.rdone = 1'b1;
                    @(negedge clk27mhz);
                end
                bus_a.rdone = 1'b0;
            end
        end
    end

    initial begin
        bus_b.outen = 1'b0; bus_b.rdone = 1'b0; bus_b.outbyte = 8'h00;
        forever begin
            @(negedge clk27mhz);
            if (resetn && bus_b.rstart) begin
                for (int i = 0; i < 4 && resetn; i++) @(negedge clk27mhz);
                for (int i = 0; i < 513 && resetn; i++) begin
                    bus_b.outen = 1'b1;
                    bus_b.outbyte = (i == 512) ? 8'h5A : 8'(i);
                    @(negedge clk27mhz);
                end
                bus_b.outen = 1'b0;
                if (resetn) begin
                    bus_b.rdone = 1'b1;
                    @(negedge clk27mhz);
                end
                bus_b.rdone = 1'b0;
            end
        end
    end

    // Downstream for the 64-bit loader refuses every third cycle.
    initial begin
        int cyc = 0;
        bus_b.wready = 1'b0;
        forever begin
            @(posedge clk27mhz);
            #1;
            cyc++;
            bus_b.wready = (cyc % 3) != 2;
        end
    end

    int          a_xfers, a_rstarts, a_data_err, a_stall_err, a_pulse_err;
    logic [31:0] a_sect [4];
    logic [31:0] a_first_data, a_first_addr, a_last_data, a_last_addr, a_prev_data, a_prev_addr;
    logic        a_prev_stall, a_prev_rstart;

    always @(negedge clk27mhz) begin
        if (!resetn) begin
            a_xfers = 0; a_rstarts = 0; a_data_err = 0; a_stall_err = 0; a_pulse_err = 0;
            a_prev_stall = 1'b0; a_prev_rstart = 1'b0;
        end else begin
            if (a_prev_stall && !(bus_a.WE && bus_a.DATA == a_prev_data && bus_a.WADDR == a_prev_addr))
                a_stall_err++;
            if (bus_a.rstart) begin
                if (a_prev_rstart) a_pulse_err++;
                else begin
                    if (a_rstarts < 4) a_sect[a_rstarts] = bus_a.rsector;
                    a_rstarts++;
                end
            end
            a_prev_rstart = bus_a.rstart;
            if (bus_a.WE && bus_a.wready) begin
                if (a_xfers == 0) begin
                    a_first_data = bus_a.DATA;
                    a_first_addr = bus_a.WADDR;
                end
                if (bus_a.WADDR !== 32'(a_xfers * 4) || 64'(bus_a.DATA) !== exp_word(a_xfers * 4, 4, 1024))
                    a_data_err++;
                a_last_data = bus_a.DATA;
                a_last_addr = bus_a.WADDR;
                a_xfers++;
            end
            a_prev_stall = bus_a.WE && !bus_a.wready;
            a_prev_data  = bus_a.DATA;
            a_prev_addr  = bus_a.WADDR;
        end
    end

    int          b_xfers, b_rstarts, b_data_err, b_stall_err, b_pulse_err;
    logic [31:0] b_sect [4];
    logic [63:0] b_first_data, b_last_data, b_prev_data;
    logic [31:0] b_last_addr, b_prev_addr;
    logic        b_prev_stall, b_prev_rstart;

    always @(negedge clk27mhz) begin
        if (!resetn) begin
            b_xfers = 0; b_rstarts = 0; b_data_err = 0; b_stall_err = 0; b_pulse_err = 0;
            b_prev_stall = 1'b0; b_prev_rstart = 1'b0;
        end else begin
            if (b_prev_stall && !(bus_b.WE && bus_b.DATA == b_prev_data && bus_b.WADDR == b_prev_addr))
                b_stall_err++;
            if (bus_b.rstart) begin
                if (b_prev_rstart) b_pulse_err++;
                else begin
                    if (b_rstarts < 4) b_sect[b_rstarts] = bus_b.rsector;
                    b_rstarts++;
                end
            end
            b_prev_rstart = bus_b.rstart;
            if (bus_b.WE && bus_b.wready) begin
                if (b_xfers == 0) b_first_data = bus_b.DATA;
                if (bus_b.WADDR !== 32'(b_xfers * 8) || bus_b.DATA !== exp_word(b_xfers * 8, 8, 1030))
                    b_data_err++;
                b_last_data = bus_b.DATA;
                b_last_addr = bus_b.WADDR;
                b_xfers++;
            end
            b_prev_stall = bus_b.WE && !bus_b.wready;
            b_prev_data  = bus_b.DATA;
            b_prev_addr  = bus_b.WADDR;
        end
    end

    int c_rstarts;
    always @(negedge clk27mhz) begin
        if (!resetn) c_rstarts = 0;
        else if (bus_c.rstart) c_rstarts++;
    end

    initial begin
        int budget;
        int exp_sum;
        resetn = 1'b0;
        go_a = 1'b0; go_b = 1'b0; go_c = 1'b1;
        bus_a.wready = 1'b0;
        bus_c.rdone = 1'b0; bus_c.outen = 1'b0; bus_c.outbyte = 8'h00; bus_c.wready = 1'b1;
        tick(3);

        check("reset_we",      64'(bus_a.WE),      64'd0);
        check("reset_done",    64'(done_a),        64'd0);
        check("reset_busy",    64'(busy_a),        64'd0);
        check("reset_rstart",  64'(bus_a.rstart),  64'd0);
        check("reset_rsector", 64'(bus_a.rsector), 64'd8);
        check("reset_waddr",   64'(bus_a.WADDR),   64'd0);
        check("reset_data",    64'(bus_a.DATA),    64'd0);
        check("reset_done_c",  64'(done_c),        64'd0);

        // Ping-pong: downstream stalled, both sectors must land, nothing more requested.
        go_a = 1'b1; go_b = 1'b1;
        resetn = 1'b1;
        tick(3);
        check("empty_done",    64'(done_c),    64'd1);
        check("empty_busy",    64'(busy_c),    64'd0);
        tick(1997);
        check("empty_rstarts", 64'(c_rstarts), 64'd0);
        check("pp_rstarts",    64'(a_rstarts),    64'd2);
        check("pp_sector0",    64'(a_sect[0]),    64'd8);
        check("pp_sector1",    64'(a_sect[1]),    64'd9);
        check("pp_we_held",    64'(bus_a.WE),     64'd1);
        check("pp_waddr",      64'(bus_a.WADDR),  64'd0);
        check("pp_data",       64'(bus_a.DATA),   64'h03020100);
        check("pp_no_xfer",    64'(a_xfers),      64'd0);
        check("pp_busy",       64'(busy_a),       64'd1);

        bus_a.wready = 1'b1;
        budget = 0;
        while (!done_a && budget < 3000) begin tick(1); budget++; end
        check("a_done",        64'(done_a),       64'd1);
        check("a_xfers",       64'(a_xfers),      64'd256);
        check("a_first_data",  64'(a_first_data), 64'h03020100);
        check("a_first_addr",  64'(a_first_addr), 64'd0);
        check("a_last_data",   64'(a_last_data),  64'hFFFEFDFC);
        check("a_last_addr",   64'(a_last_addr),  64'd1020);
        check("a_data_err",    64'(a_data_err),   64'd0);
        check("a_stall_err",   64'(a_stall_err),  64'd0);
        check("a_pulse_err",   64'(a_pulse_err),  64'd0);
        tick(100);
        check("a_no_third",    64'(a_rstarts),    64'd2);
        check("a_we_after",    64'(bus_a.WE),     64'd0);
        check("a_busy_after",  64'(busy_a),       64'd0);

        budget = 0;
        while (!done_b && budget < 5000) begin tick(1); budget++; end
        tick(100);
        check("b_done",        64'(done_b),       64'd1);
        check("b_xfers",       64'(b_xfers),      64'd129);
        check("b_first_data",  b_first_data,      64'h0706050403020100);
        check("b_last_addr",   64'(b_last_addr),  64'd1024);
        check("b_last_data",   b_last_data,       64'h0000050403020100);
        check("b_rstarts",     64'(b_rstarts),    64'd3);
        check("b_sector2",     64'(b_sect[2]),    64'd2);
        check("b_data_err",    64'(b_data_err),   64'd0);
        check("b_stall_err",   64'(b_stall_err),  64'd0);
        check("b_pulse_err",   64'(b_pulse_err),  64'd0);
`ifdef SD_BURST_LOADER_CHECKSUM_EN
        exp_sum = 0;
        for (int i = 0; i < 1030; i++) exp_sum += i % 256;
        check("b_csum",        64'(csum_b),       64'(exp_sum));
`endif

        // go dropped right after the first rdone: buffer 0 drains, no second request.
        go_b = 1'b0;
        resetn = 1'b0;
        tick(2);
        resetn = 1'b1;
        budget = 0;
        while (!bus_a.rdone && budget < 2000) begin tick(1); budget++; end
        check("go_rdone_seen", 64'(bus_a.rdone),  64'd1);
        go_a = 1'b0;
        tick(1000);
        check("go_xfers",      64'(a_xfers),      64'd128);
        check("go_rstarts",    64'(a_rstarts),    64'd1);
        check("go_we",         64'(bus_a.WE),     64'd0);
        check("go_done",       64'(done_a),       64'd0);
        check("go_data_err",   64'(a_data_err),   64'd0);
        go_a = 1'b1;
        budget = 0;
        while (!bus_a.rstart && budget < 20) begin tick(1); budget++; end
        check("go_resume",     64'(bus_a.rstart), 64'd1);
        check("go_rsector",    64'(bus_a.rsector), 64'd9);

        // Asynchronous reset in the middle of a drain.
        resetn = 1'b0;
        tick(2);
        resetn = 1'b1;
        budget = 0;
        while (!(bus_a.WE && bus_a.WADDR == 32'd200) && budget < 3000) begin tick(1); budget++; end
        check("rst_at_200",    64'(bus_a.WADDR),  64'd200);
        #2 resetn = 1'b0;
        #1;
        check("rst_we",        64'(bus_a.WE),     64'd0);
        check("rst_busy",      64'(busy_a),       64'd0);
        check("rst_done_a",    64'(done_a),       64'd0);
        check("rst_done_c",    64'(done_c),       64'd0);
        tick(2);
        resetn = 1'b1;
        budget = 0;
        while (!bus_a.rstart && budget < 20) begin tick(1); budget++; end
        check("rst_rstart",    64'(bus_a.rstart),  64'd1);
        check("rst_rsector",   64'(bus_a.rsector), 64'd8);
        budget = 0;
        while (!bus_a.WE && budget < 2000) begin tick(1); budget++; end
        check("rst_restart_we", 64'(bus_a.WE),    64'd1);
        check("rst_waddr",     64'(bus_a.WADDR),  64'd0);
        check("rst_data",      64'(bus_a.DATA),   64'h03020100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
